// File: rtl/mod_cycle_exposure_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mod_cycle_exposure_ctrl_pkg
//   Definitions shared by the mbi exposure control blocks: sequencer state
//   type, DRAIN_B polarity constants and default field widths.
// ----------------------------------------------------------------------------
package mod_cycle_exposure_ctrl_pkg;

  // Exposure sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_ALIGN = 3'd2,
    ST_INTEG = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // DRAIN_B is active-low: 0 holds the imager in drain, 1 lets it integrate
  localparam logic DRAIN_ASSERT  = 1'b0;
  localparam logic DRAIN_RELEASE = 1'b1;

  // Default widths
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_DRAIN_W   = 8;
  localparam int unsigned DEF_TIMEOUT_W = 16;

endpackage

// File: rtl/mod_cycle_exposure_ctrl_sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
//   Two-flop synchronizer followed by a registered rising-edge detector.
//   rise_o is a one-cycle pulse 3 clk_i edges after d_i rises.
// Ports
//   clk_i   in  1  sampling clock
//   rst_ni  in  1  asynchronous active-low reset
//   d_i     in  1  asynchronous input
//   rise_o  out 1  registered rising-edge pulse
// ----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic sync_dly_q;
  logic rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      meta_q     <= d_i;
      sync_q     <= meta_q;
      sync_dly_q <= sync_q;
      rise_q     <= sync_q & ~sync_dly_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/mod_cycle_exposure_ctrl.sv
// ----------------------------------------------------------------------------
// mod_cycle_exposure_ctrl
//   Exposure sequencer for the modulated imager. Holds DRAIN_B low for a drain
//   period, releases it on a (synchronized) rising edge of MOD_SIG_AND and
//   re-asserts it exactly NUM_MOD_CYCLES modulation periods later. Supports
//   single-shot / continuous framing, abort and a stalled-modulation watchdog.
// Ports
//   USER_CLOCK      in  1        system clock
//   RESET_B         in  1        asynchronous active-low reset
//   MOD_SIG_AND     in  1        modulation clock (asynchronous)
//   START           in  1        pulse: latch config and begin (ignored when BUSY)
//   ABORT           in  1        return to IDLE at once, no FRAME_DONE
//   CONTINUOUS      in  1        latched at START: repeat frames until ABORT
//   NUM_MOD_CYCLES  in  CNT_W    exposure length in mod periods (0 -> 1)
//   DRAIN_LEN       in  DRAIN_W  drain hold in USER_CLOCK cycles (0 -> 1)
//   DRAIN_B         out 1        0 = draining
//   EXPOSING        out 1        1 while DRAIN_B high
//   BUSY            out 1        1 in any state but IDLE
//   FRAME_DONE      out 1        one-cycle pulse per completed exposure
//   FRAME_COUNT     out CNT_W    completed frames since START (wraps)
//   STALL_ERR       out 1        sticky watchdog flag, cleared by next START
// ----------------------------------------------------------------------------
module mod_cycle_exposure_ctrl
  import mod_cycle_exposure_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned DRAIN_W   = DEF_DRAIN_W,
  parameter int unsigned TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic               USER_CLOCK,
  input  logic               RESET_B,
  input  logic               MOD_SIG_AND,
  input  logic               START,
  input  logic               ABORT,
  input  logic               CONTINUOUS,
  input  logic [CNT_W-1:0]   NUM_MOD_CYCLES,
  input  logic [DRAIN_W-1:0] DRAIN_LEN,
  output logic               DRAIN_B,
  output logic               EXPOSING,
  output logic               BUSY,
  output logic               FRAME_DONE,
  output logic [CNT_W-1:0]   FRAME_COUNT,
  output logic               STALL_ERR
);

  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  logic mod_edge;

  state_e               state_q;
  logic [DRAIN_W-1:0]   drain_cnt_q;
  logic [DRAIN_W-1:0]   drain_cfg_q;
  logic [CNT_W-1:0]     num_cfg_q;
  logic                 cont_cfg_q;
  logic [CNT_W-1:0]     mod_cnt_q;
  logic [TIMEOUT_W-1:0] wdog_q;

  logic                 drain_b_q;
  logic                 expo_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic [CNT_W-1:0]     frame_cnt_q;
  logic                 stall_q;

  logic [DRAIN_W-1:0]   drain_len_eff;
  logic [CNT_W-1:0]     num_eff;
  logic                 wdog_expire;

  sync_edge_det u_mod_sync (
    .clk_i  (USER_CLOCK),
    .rst_ni (RESET_B),
    .d_i    (MOD_SIG_AND),
    .rise_o (mod_edge)
  );

  always_comb begin
    drain_len_eff = (DRAIN_LEN == '0) ? DRAIN_W'(1) : DRAIN_LEN;
    num_eff       = (NUM_MOD_CYCLES == '0) ? CNT_W'(1) : NUM_MOD_CYCLES;
    // Expire on the edge at which the counter would reach all-ones, so the
    // stall reaction lands after 2**TIMEOUT_W-1 edge-free cycles.
    wdog_expire   = (wdog_q == (WD_MAX - TIMEOUT_W'(1)));
  end

  always_ff @(posedge USER_CLOCK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q      <= ST_IDLE;
      drain_cnt_q  <= '0;
      drain_cfg_q  <= '0;
      num_cfg_q    <= '0;
      cont_cfg_q   <= 1'b0;
      mod_cnt_q    <= '0;
      wdog_q       <= '0;
      drain_b_q    <= DRAIN_ASSERT;
      expo_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      stall_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (ABORT) begin
        // Abort overrides any transition, including a coincident mod edge
        state_q   <= ST_IDLE;
        drain_b_q <= DRAIN_ASSERT;
        expo_q    <= 1'b0;
        busy_q    <= 1'b0;
        wdog_q    <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (START) begin
              state_q     <= ST_DRAIN;
              busy_q      <= 1'b1;
              stall_q     <= 1'b0;
              frame_cnt_q <= '0;
              drain_cnt_q <= drain_len_eff;
              drain_cfg_q <= drain_len_eff;
              num_cfg_q   <= num_eff;
              cont_cfg_q  <= CONTINUOUS;
            end
          end

          ST_DRAIN: begin
            if (drain_cnt_q == DRAIN_W'(1)) begin
              state_q <= ST_ALIGN;
              wdog_q  <= '0;
            end else begin
              drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
            end
          end

          ST_ALIGN: begin
            if (mod_edge) begin
              state_q   <= ST_INTEG;
              mod_cnt_q <= num_cfg_q;
              drain_b_q <= DRAIN_RELEASE;
              expo_q    <= 1'b1;
              wdog_q    <= '0;
            end else if (wdog_expire) begin
              state_q   <= ST_IDLE;
              stall_q   <= 1'b1;
              drain_b_q <= DRAIN_ASSERT;
              expo_q    <= 1'b0;
              busy_q    <= 1'b0;
              wdog_q    <= '0;
            end else begin
              wdog_q <= wdog_q + TIMEOUT_W'(1);
            end
          end

          ST_INTEG: begin
            if (mod_edge) begin
              wdog_q <= '0;
              // Release and re-assert both follow the same synchronized edge
              // path, so the high time is an exact multiple of the mod period.
              if (mod_cnt_q == CNT_W'(1)) begin
                state_q      <= ST_DONE;
                drain_b_q    <= DRAIN_ASSERT;
                expo_q       <= 1'b0;
                frame_done_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
              end else begin
                mod_cnt_q <= mod_cnt_q - CNT_W'(1);
              end
            end else if (wdog_expire) begin
              state_q   <= ST_IDLE;
              stall_q   <= 1'b1;
              drain_b_q <= DRAIN_ASSERT;
              expo_q    <= 1'b0;
              busy_q    <= 1'b0;
              wdog_q    <= '0;
            end else begin
              wdog_q <= wdog_q + TIMEOUT_W'(1);
            end
          end

          ST_DONE: begin
            if (cont_cfg_q) begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= drain_cfg_q;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end

          default: begin
            state_q   <= ST_IDLE;
            drain_b_q <= DRAIN_ASSERT;
            expo_q    <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DRAIN_B     = drain_b_q;
  assign EXPOSING    = expo_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = frame_done_q;
  assign FRAME_COUNT = frame_cnt_q;
  assign STALL_ERR   = stall_q;

endmodule

// File: tb/tb_mod_cycle_exposure_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mod_cycle_exposure_ctrl
//   Self-checking bench for mod_cycle_exposure_ctrl. A free-running modulation
//   source is generated on a cycle grid; a monitor records DRAIN_B intervals and
//   FRAME_DONE pulses, and the main sequence compares them against values
//   derived from the exposure rules (high time = max(NUM,1) * mod period).
// ----------------------------------------------------------------------------
module tb_mod_cycle_exposure_ctrl;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned DRAIN_W   = 8;
  localparam int unsigned TIMEOUT_W = 8;
  localparam int          WD_IDLE   = 255;  // 2**TIMEOUT_W - 1
  localparam int          SYNC_LAT  = 3;    // pin edge -> mod_edge

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               mod_pin = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               cont = 1'b0;
  logic [CNT_W-1:0]   num = '0;
  logic [DRAIN_W-1:0] dlen = '0;
  logic               drain_b;
  logic               exposing;
  logic               busy;
  logic               frame_done;
  logic [CNT_W-1:0]   frame_count;
  logic               stall_err;

  always #5 clk = ~clk;

  mod_cycle_exposure_ctrl #(
    .CNT_W     (CNT_W),
    .DRAIN_W   (DRAIN_W),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .USER_CLOCK     (clk),
    .RESET_B        (rst_n),
    .MOD_SIG_AND    (mod_pin),
    .START          (start),
    .ABORT          (abort),
    .CONTINUOUS     (cont),
    .NUM_MOD_CYCLES (num),
    .DRAIN_LEN      (dlen),
    .DRAIN_B        (drain_b),
    .EXPOSING       (exposing),
    .BUSY           (busy),
    .FRAME_DONE     (frame_done),
    .FRAME_COUNT    (frame_count),
    .STALL_ERR      (stall_err)
  );

  // Cycle index, advanced at each rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Modulation source: rises every 'per' cycles, 3 ns after a clock edge
  int per = 100;
  bit mod_en = 1'b1;
  int ph = 0;
  int rise_cyc = -1000;
  always @(posedge clk) begin
    #3;
    if (!mod_en) begin
      mod_pin = 1'b0;
      ph = 0;
    end else begin
      if (ph == 0) begin
        mod_pin = 1'b1;
        rise_cyc = cyc;
      end else if (ph == per / 2) begin
        mod_pin = 1'b0;
      end
      ph = (ph + 1 >= per) ? 0 : ph + 1;
    end
  end

  // Monitor: records events only; all judging is done by the main sequence
  logic prev_db = 1'b0;
  logic prev_fd = 1'b0;
  int   fd_cnt = 0;
  int   fd_wide = 0;
  int   expo_bad = 0;
  int   rise_at = 0;
  int   hi_q[$];
  int   align_q[$];
  int   rise_q[$];
  always @(negedge clk) begin
    if (exposing !== drain_b) expo_bad++;
    if (drain_b && !prev_db) begin
      rise_at = cyc;
      align_q.push_back(cyc - rise_cyc);
      rise_q.push_back(cyc);
    end
    if (!drain_b && prev_db) hi_q.push_back(cyc - rise_at);
    if (frame_done) begin
      fd_cnt++;
      if (prev_fd) fd_wide++;
    end
    prev_db = drain_b;
    prev_fd = frame_done;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic pulse_start(output int sc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_busy_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_db(input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drain_b == val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference: one single-shot frame
  task automatic run_frame(input string nm, input int n, input int d, input int p);
    int  sc, fdb, hib, alb, exp_hi, deff;
    bit  ok;
    exp_hi = ((n == 0) ? 1 : n) * p;
    deff   = (d == 0) ? 1 : d;
    @(negedge clk);
    num = CNT_W'(n);
    dlen = DRAIN_W'(d);
    cont = 1'b0;
    per = p;
    fdb = fd_cnt;
    hib = hi_q.size();
    alb = align_q.size();
    pulse_start(sc);
    chk({nm, " busy_after_start"}, busy, 1);
    wait_busy_low(deff + (exp_hi + 3 * p) + 50, ok);
    chk({nm, " done_in_time"}, ok, 1);
    chk({nm, " frame_done_pulses"}, fd_cnt - fdb, 1);
    chk({nm, " frame_count"}, frame_count, 1);
    chk({nm, " drain_b_end"}, drain_b, 0);
    chk({nm, " stall_err"}, stall_err, 0);
    chk({nm, " exposures"}, hi_q.size() - hib, 1);
    if (hi_q.size() > hib) chk({nm, " high_time"}, hi_q[hib], exp_hi);
    if (align_q.size() > alb) begin
      chk({nm, " align"}, align_q[alb], SYNC_LAT + 1);
      chk_rng({nm, " drain_hold"}, rise_q[alb] - sc, deff, deff + 2 * p + 10);
    end
  endtask

  typedef struct {
    int num;
    int dlen;
    int per;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  sc, fdb, hib, n, d, p, lr;
    bit  ok;

    vecs[0] = '{num: 4, dlen: 10,  per: 100};
    vecs[1] = '{num: 0, dlen: 0,   per: 100};
    vecs[2] = '{num: 3, dlen: 5,   per: 20};
    vecs[3] = '{num: 1, dlen: 255, per: 12};
    vecs[4] = '{num: 7, dlen: 1,   per: 8};
    vecs[5] = '{num: 2, dlen: 0,   per: 9};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst drain_b", drain_b, 0);
    chk("rst exposing", exposing, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst frame_count", frame_count, 0);
    chk("rst stall_err", stall_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven single frames
    foreach (vecs[i]) begin
      run_frame($sformatf("vec%0d", i), vecs[i].num, vecs[i].dlen, vecs[i].per);
    end

    // Randomized single frames
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(0, 6));
      d = int'($urandom_range(0, 20));
      p = int'($urandom_range(8, 40));
      run_frame($sformatf("rnd%0d", i), n, d, p);
    end

    // Continuous framing, then abort in the sixth exposure
    @(negedge clk);
    num = 16'd2; dlen = 8'd3; cont = 1'b1; per = 20;
    fdb = fd_cnt;
    hib = hi_q.size();
    pulse_start(sc);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fd_cnt - fdb >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("cont five_frames_in_time", ok, 1);
    wait_db(1'b1, 200, ok);
    chk("cont sixth_exposure_started", ok, 1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort drain_b", drain_b, 0);
    chk("abort exposing", exposing, 0);
    chk("abort busy", busy, 0);
    repeat (150) @(negedge clk);
    chk("abort frame_done_pulses", fd_cnt - fdb, 5);
    chk("abort frame_count", frame_count, 5);
    for (int i = 0; i < 5; i++) begin
      if (hi_q.size() > hib + i) chk($sformatf("cont high_time%0d", i), hi_q[hib + i], 40);
    end
    cont = 1'b0;

    // Stalled modulation during integration
    @(negedge clk);
    num = 16'd5; dlen = 8'd2; per = 30;
    fdb = fd_cnt;
    pulse_start(sc);
    wait_db(1'b1, 200, ok);
    chk("stall exposure_started", ok, 1);
    repeat (40) @(negedge clk);
    mod_en = 1'b0;
    @(negedge clk);
    lr = rise_cyc;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (stall_err) begin
        ok = 1'b1;
        break;
      end
    end
    chk("stall flagged", ok, 1);
    chk_rng("stall latency", cyc - lr, WD_IDLE + SYNC_LAT, WD_IDLE + SYNC_LAT + 2);
    chk("stall drain_b", drain_b, 0);
    chk("stall busy", busy, 0);
    chk("stall no_frame_done", fd_cnt - fdb, 0);
    mod_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("stall sticky", stall_err, 1);
    run_frame("post_stall", 1, 1, 30);

    // START while busy with new config, and START coincident with DONE
    @(negedge clk);
    num = 16'd4; dlen = 8'd4; per = 25;
    fdb = fd_cnt;
    hib = hi_q.size();
    pulse_start(sc);
    repeat (30) @(negedge clk);
    num = 16'd9; dlen = 8'd50; cont = 1'b1;
    pulse_start(sc);
    wait_db(1'b1, 200, ok);
    wait_db(1'b0, 400, ok);
    chk("busy_start fall_seen", ok, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start ignored", busy, 0);
    repeat (3) @(negedge clk);
    chk("done_start still_idle", busy, 0);
    chk("busy_start frame_done_pulses", fd_cnt - fdb, 1);
    chk("busy_start frame_count", frame_count, 1);
    if (hi_q.size() > hib) chk("busy_start high_time", hi_q[hib], 100);
    cont = 1'b0;

    // Asynchronous reset mid-exposure
    @(negedge clk);
    num = 16'd1; dlen = 8'd2; cont = 1'b1; per = 25;
    fdb = fd_cnt;
    pulse_start(sc);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fd_cnt - fdb >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_mid first_frame", ok, 1);
    wait_db(1'b1, 200, ok);
    repeat (10) @(negedge clk);
    chk("rst_mid pre_count", frame_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid drain_b", drain_b, 0);
    chk("rst_mid exposing", exposing, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid frame_done", frame_done, 0);
    chk("rst_mid frame_count", frame_count, 0);
    chk("rst_mid stall_err", stall_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cont = 1'b0;
    repeat (5) @(negedge clk);

    // Whole-run invariants
    chk("exposing_tracks_drain_b", expo_bad, 0);
    chk("frame_done_single_cycle", fd_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #3000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end

endmodule
